// File: rtl/maf_pkg.sv
// Shared constants and helpers for the moving-average filter.
// Defaults match the audio path: 24-bit stereo, 8-tap window.
package maf_pkg;

    localparam int MAF_DATA_W     = 24;
    localparam int MAF_LOG2_DEPTH = 3;
    localparam int MAF_NUM_CH     = 2;

    // Accumulator width that holds the sum of 2**log2_depth samples exactly.
    function automatic int acc_width(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

endpackage

// File: rtl/maf_channel.sv
// One channel of the running-sum boxcar: history ring, accumulator,
// and the floor-divided average of the sum including the current sample.
module maf_channel
    import maf_pkg::*;
#(
    parameter int DATA_W     = MAF_DATA_W,
    parameter int LOG2_DEPTH = MAF_LOG2_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  accept,
    input  logic                  flush,
    input  logic [LOG2_DEPTH-1:0] wptr,
    input  logic [DATA_W-1:0]     x,
    output logic [DATA_W-1:0]     avg
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = acc_width(DATA_W, LOG2_DEPTH);

    logic [DATA_W-1:0]       hist [DEPTH];
    logic [DATA_W-1:0]       oldest;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] old_ext;

    // Sample leaving the window is the one about to be overwritten.
    assign oldest  = hist[wptr];
    assign x_ext   = {{LOG2_DEPTH{x[DATA_W-1]}}, x};
    assign old_ext = {{LOG2_DEPTH{oldest[DATA_W-1]}}, oldest};

    // Running sum: one add and one subtract per sample.
    always_comb begin
        acc_next = acc + x_ext - old_ext;
    end

    // Dropping the low bits is an arithmetic shift (floor); the top DATA_W
    // bits of an exact sum of DEPTH samples always fit in DATA_W.
    assign avg = acc_next[LOG2_DEPTH +: DATA_W];

    // History ring storage, written at the shared write pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            hist[wptr] <= x;
        end
    end

    // Accumulator tracks the exact sum of the window contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (flush) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/moving_average_filter.sv
// Multi-channel running-sum moving-average filter with valid/ready
// handshakes, a one-entry output register, bypass and flush.
module moving_average_filter
    import maf_pkg::*;
#(
    parameter int DATA_W     = MAF_DATA_W,
    parameter int LOG2_DEPTH = MAF_LOG2_DEPTH,
    parameter int NUM_CH     = MAF_NUM_CH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic                     bypass,
    input  logic                     flush,
    output logic [LOG2_DEPTH:0]      fill_count
);

    localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(2 ** LOG2_DEPTH);

    logic                     accept;
    logic [LOG2_DEPTH-1:0]    wptr;
    logic [NUM_CH*DATA_W-1:0] avg_vec;

    // Output register frees up when empty or being drained; flush blocks input.
    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            maf_channel #(
                .DATA_W     (DATA_W),
                .LOG2_DEPTH (LOG2_DEPTH)
            ) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .accept  (accept),
                .flush   (flush),
                .wptr    (wptr),
                .x       (in_data[c*DATA_W +: DATA_W]),
                .avg     (avg_vec[c*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Shared write pointer wraps naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
        end else if (flush) begin
            wptr <= '0;
        end else if (accept) begin
            wptr <= wptr + 1'b1;
        end
    end

    // Window occupancy, saturating once the window is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_count <= '0;
        end else if (flush) begin
            fill_count <= '0;
        end else if (accept && fill_count != FILL_MAX) begin
            fill_count <= fill_count + 1'b1;
        end
    end

    // Output stage: load on accept, retire on out_ready, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= bypass ? in_data : avg_vec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Self-checking bench for moving_average_filter (DEPTH=8, 2 channels).
// Reference keeps the last DEPTH accepted samples and floor-divides their sum.
module tb_moving_average_filter;

    localparam int DW    = 24;
    localparam int LD    = 3;
    localparam int DEPTH = 8;
    localparam int MAXP  = 8388607;
    localparam int MINN  = -8388608;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*DW-1:0] out_data;
    logic          bypass = 1'b0;
    logic          flush = 1'b0;
    logic [LD:0]   fill_count;

    int n_cmp = 0;
    int n_bad = 0;

    longint w0[$];
    longint w1[$];
    bit         ev;
    logic [DW-1:0] ed0, ed1;
    int         fill;

    always #5 clk = ~clk;

    moving_average_filter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bypass     (bypass),
        .flush      (flush),
        .fill_count (fill_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] favg(input longint q[$]);
        longint s, r;
        s = 0;
        foreach (q[i]) s += q[i];
        r = s / DEPTH;
        if ((s % DEPTH) != 0 && s < 0) r -= 1;
        return DW'(r);
    endfunction

    task automatic model_clear();
        w0 = {};
        w1 = {};
        for (int i = 0; i < DEPTH; i++) begin
            w0.push_back(0);
            w1.push_back(0);
        end
        ev   = 1'b0;
        ed0  = '0;
        ed1  = '0;
        fill = 0;
    endtask

    task automatic step(input bit iv, input int d0, input int d1,
                        input bit byp, input bit ordy, input bit fl);
        bit rdy;
        bit acc;
        in_valid  = iv;
        in_data   = {DW'(d1), DW'(d0)};
        bypass    = byp;
        out_ready = ordy;
        flush     = fl;
        rdy = (!ev || ordy) && !fl;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clk);
        acc = iv && rdy;
        if (fl) begin
            model_clear();
        end else if (acc) begin
            w0.push_back(longint'(d0));
            w1.push_back(longint'(d1));
            w0.delete(0);
            w1.delete(0);
            ev  = 1'b1;
            ed0 = byp ? DW'(d0) : favg(w0);
            ed1 = byp ? DW'(d1) : favg(w1);
            if (fill < DEPTH) fill++;
        end else if (ordy) begin
            ev = 1'b0;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_ch0", 64'(out_data[DW-1:0]), 64'(ed0));
        chk("out_ch1", 64'(out_data[2*DW-1:DW]), 64'(ed1));
        chk("fill_count", 64'(fill_count), 64'(fill));
    endtask

    initial begin
        int r0, r1;
        logic [DW-1:0] k;
        model_clear();

        // reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_fill", 64'(fill_count), 64'(0));
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // step response
        for (int i = 0; i < 10; i++) begin
            step(1, 800, 0, 0, 1, 0);
            k = (i < 8) ? DW'(100 * (i + 1)) : DW'(800);
            chk("step_const", 64'(out_data[DW-1:0]), 64'(k));
        end
        chk("step_fill_sat", 64'(fill_count), 64'(8));

        // negative rounding
        step(0, 0, 0, 0, 1, 1);
        step(1, -1, 7, 0, 1, 0);
        k = '1;
        chk("neg_first", 64'(out_data[DW-1:0]), 64'(k));
        chk("neg_ch1", 64'(out_data[2*DW-1:DW]), 64'(0));
        for (int i = 0; i < 8; i++) step(1, 0, 7, 0, 1, 0);
        chk("neg_settle", 64'(out_data[DW-1:0]), 64'(0));

        // extremes
        for (int i = 0; i < 20; i++) step(1, MAXP, MINN, 0, 1, 0);
        k = 24'h7FFFFF;
        chk("max_settle", 64'(out_data[DW-1:0]), 64'(k));
        for (int i = 0; i < 20; i++) step(1, MINN, MAXP, 0, 1, 0);
        k = 24'h800000;
        chk("min_settle", 64'(out_data[DW-1:0]), 64'(k));

        // backpressure
        step(0, 0, 0, 0, 1, 1);
        step(1, 40, -40, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 16, 16, 0, 0, 0);
        chk("bp_one_sample", 64'(fill_count), 64'(2));
        step(0, 0, 0, 0, 1, 0);
        step(1, 24, -8, 0, 1, 0);
        step(1, 24, -8, 0, 1, 0);

        // bypass then flush
        step(0, 0, 0, 0, 1, 1);
        step(1, 3, 0, 1, 1, 0);
        step(1, 5, 0, 1, 1, 0);
        step(1, 9, 0, 1, 1, 0);
        chk("byp_last", 64'(out_data[DW-1:0]), 64'(9));
        step(1, 77, 77, 0, 1, 1);
        step(1, 8, 0, 0, 1, 0);
        chk("flush_avg", 64'(out_data[DW-1:0]), 64'(1));
        chk("flush_fill", 64'(fill_count), 64'(1));

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            r0 = int'($urandom) >>> 8;
            r1 = int'($urandom) >>> 8;
            step($urandom_range(0, 3) != 0, r0, r1,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0);
        end

        // async reset between edges
        for (int i = 0; i < 3; i++) step(1, 500, 500, 0, 1, 0);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_data", 64'(out_data), 64'(0));
        chk("arst_fill", 64'(fill_count), 64'(0));
        #2;
        reset_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        step(1, 64, 0, 0, 1, 0);
        chk("arst_first", 64'(out_data[DW-1:0]), 64'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
